// File: rtl/lzf_pkg.sv
// Shared types, constants and helpers for the LZF encoder source-fetch path.
package lzf_pkg;

    localparam int unsigned LZF_WORD_BYTES = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } lzf_state_e;

    // Words needed to carry cnt bytes; the extra result bit keeps +7 from wrapping.
    function automatic logic [32:0] lzf_word_count(input logic [31:0] cnt);
        logic [32:0] w_sum;
        w_sum = {1'b0, cnt} + 33'd7;
        return w_sum >> 3;
    endfunction

endpackage

// File: rtl/lzf_word_shifter.sv
// One FIFO word held for little-endian byte extraction, with a count of bytes still valid.
module lzf_word_shifter
    import lzf_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_load,
    input  logic [LZF_WORD_BYTES*8-1:0] i_data,
    input  logic [3:0]                  i_cnt,
    input  logic                        i_shift,
    output logic [LZF_WORD_BYTES*8-1:0] o_data,
    output logic [3:0]                  o_cnt
);

    logic [LZF_WORD_BYTES*8-1:0] r_data;
    logic [3:0]                  r_cnt;

    // Load wins over shift so a drained word can be replaced on the same edge.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= i_cnt;
        end else if (i_shift && (r_cnt != 4'd0)) begin
            r_data <= {8'h00, r_data[LZF_WORD_BYTES*8-1:8]};
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    assign o_data = r_data;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/lzf_src_fetch.sv
// Pops 64-bit source words and serialises them into a byte stream for the LZS core,
// trimming the final partial word and signalling end of job on m_endn.
module lzf_src_fetch #(
    parameter int unsigned LZF_WIDTH      = 20,
    parameter int unsigned LZF_WORD_BYTES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [LZF_WIDTH-1:0] fi_cnt,
    input  logic                 m_src_empty,
    output logic                 m_src_getn,
    input  logic [63:0]          fi,
    output logic [7:0]           byte_data,
    output logic                 byte_valid,
    output logic                 byte_last,
    input  logic                 byte_ready,
    output logic                 m_endn
);

    import lzf_pkg::*;

    localparam logic [3:0] FULL_CNT = 4'(LZF_WORD_BYTES);

    lzf_state_e           r_state, w_state_nxt;
    logic [LZF_WIDTH-1:0] r_bytes_left;
    logic [LZF_WIDTH:0]   r_words_left;
    logic [2:0]           r_tail;
    logic                 r_in_flight, r_last_word, r_endn;

    logic [63:0] w_cur_data, w_nxt_data, w_cur_din;
    logic [3:0]  w_cur_cnt, w_nxt_cnt, w_cur_cin, w_fi_cnt;
    logic        w_cur_valid, w_nxt_valid, w_accept, w_cur_drain, w_job_end;
    logic        w_pop, w_fi_to_cur, w_fi_to_nxt, w_nxt_to_cur, w_cur_load;

    assign w_cur_valid = (w_cur_cnt != 4'd0);
    assign w_nxt_valid = (w_nxt_cnt != 4'd0);
    assign byte_valid  = ce && w_cur_valid;
    assign byte_data   = w_cur_data[7:0];
    assign byte_last   = byte_valid && (r_bytes_left == LZF_WIDTH'(1));
    assign w_accept    = byte_valid && byte_ready;
    assign w_cur_drain = w_accept && (w_cur_cnt == 4'd1);
    assign w_job_end   = w_accept && byte_last;

    assign w_pop = (r_state == StRun) && ce && !m_src_empty && (r_words_left != '0)
                   && !r_in_flight && !w_nxt_valid;
    assign m_src_getn = !w_pop;
    assign m_endn     = r_endn;

    // Returning word: cur takes it when cur is free by this edge, otherwise it parks in nxt.
    assign w_fi_cnt     = (r_last_word && (r_tail != 3'd0)) ? {1'b0, r_tail} : FULL_CNT;
    assign w_fi_to_cur  = r_in_flight && (!w_cur_valid || w_cur_drain);
    assign w_fi_to_nxt  = r_in_flight && !w_fi_to_cur;
    assign w_nxt_to_cur = w_cur_drain && w_nxt_valid;
    assign w_cur_load   = w_fi_to_cur || w_nxt_to_cur;
    assign w_cur_din    = w_fi_to_cur ? fi : w_nxt_data;
    assign w_cur_cin    = w_fi_to_cur ? w_fi_cnt : w_nxt_cnt;

    lzf_word_shifter u_cur (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_load  (w_cur_load),
        .i_data  (w_cur_din),
        .i_cnt   (w_cur_cin),
        .i_shift (w_accept),
        .o_data  (w_cur_data),
        .o_cnt   (w_cur_cnt)
    );

    lzf_word_shifter u_nxt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_nxt_to_cur),
        .i_load  (w_fi_to_nxt),
        .i_data  (fi),
        .i_cnt   (w_fi_cnt),
        .i_shift (1'b0),
        .o_data  (w_nxt_data),
        .o_cnt   (w_nxt_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (ce) w_state_nxt = (fi_cnt == '0) ? StDone : StRun;
            StRun:   if (w_job_end) w_state_nxt = StDone;
            StDone:  w_state_nxt = StDone;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bytes_left <= '0;
            r_words_left <= '0;
            r_tail       <= '0;
            r_in_flight  <= 1'b0;
            r_last_word  <= 1'b0;
            r_endn       <= 1'b1;
        end else begin
            if ((r_state == StIdle) && ce) begin
                r_bytes_left <= fi_cnt;
                r_words_left <= (LZF_WIDTH + 1)'(lzf_word_count(32'(fi_cnt)));
                r_tail       <= fi_cnt[2:0];
            end
            if (w_pop) begin
                r_words_left <= r_words_left - (LZF_WIDTH + 1)'(1);
                r_last_word  <= (r_words_left == (LZF_WIDTH + 1)'(1));
            end
            // A pop is never issued while a read is in flight, so this also clears it.
            r_in_flight <= w_pop;
            if (w_accept) begin
                r_bytes_left <= r_bytes_left - LZF_WIDTH'(1);
            end
            if (w_state_nxt == StDone) begin
                r_endn <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lzf_src_fetch.sv
// Bench for lzf_src_fetch: FIFO model, byte scoreboard and per-scenario tasks.
`timescale 1ns/1ps
module tb_lzf_src_fetch;

    localparam int unsigned W = 20;

    logic         clk = 1'b0;
    logic         rst, ce, m_src_empty, m_src_getn, byte_valid, byte_last, byte_ready, m_endn;
    logic [W-1:0] fi_cnt;
    logic [63:0]  fi;
    logic [7:0]   byte_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [63:0] fifo[$];
    logic [7:0]  exp_q[$];
    bit          pop_req    = 0;
    bit          chk_stable = 0;
    bit          prev_hold  = 0;
    logic [7:0]  prev_data;
    logic        prev_last;

    always #5 clk = ~clk;

    lzf_src_fetch #(.LZF_WIDTH(W), .LZF_WORD_BYTES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .fi_cnt      (fi_cnt),
        .m_src_empty (m_src_empty),
        .m_src_getn  (m_src_getn),
        .fi          (fi),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .m_endn      (m_endn)
    );

    // FIFO model: a low getn at a rising edge pops; the word is on fi for the next cycle.
    always @(posedge clk) begin
        if (pop_req) begin
            pop_req = 0;
            if (fifo.size() > 0) fi <= fifo.pop_front();
        end
    end

    // Monitor: pops, hold stability under backpressure, and byte scoreboard.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (!m_src_getn) begin
            n_pops++;
            pop_req = 1;
            n_tests++;
            if (m_src_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL pop_while_empty: getn=0 with m_src_empty=%b, required no pop",
                         m_src_empty);
            end
        end
        if (chk_stable && prev_hold) begin
            n_tests++;
            if (byte_valid !== 1'b1 || byte_data !== prev_data || byte_last !== prev_last) begin
                n_fail++;
                $display("FAIL hold_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                         byte_valid, byte_data, byte_last, prev_data, prev_last);
            end
        end
        prev_hold = byte_valid && !byte_ready;
        prev_data = byte_data;
        prev_last = byte_last;
        if (byte_valid && byte_ready && !rst) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_byte: got %h, required no byte", byte_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (byte_data !== exp_b || byte_last !== (exp_q.size() == 0)) begin
                    n_fail++;
                    $display("FAIL byte_stream: got %h last=%b, required %h last=%b",
                             byte_data, byte_last, exp_b, (exp_q.size() == 0));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; ce = 0; byte_ready = 1; m_src_empty = 0; fi_cnt = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        fifo.delete(); exp_q.delete(); n_pops = 0; pop_req = 0;
    endtask

    task automatic load_job(input logic [7:0] base, input int nwords, input int nbytes);
        logic [63:0] w;
        for (int k = 0; k < nwords; k++) begin
            for (int j = 0; j < 8; j++) begin
                w[8*j +: 8] = base + 8'(8 * k + j);
                if (8 * k + j < nbytes) exp_q.push_back(base + 8'(8 * k + j));
            end
            fifo.push_back(w);
        end
    endtask

    task automatic wait_endn(input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (m_endn === 1'b0) ok = 1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests += 5;
        if (m_src_getn !== 1'b1) begin n_fail++; $display("FAIL rst_getn: got %b, required 1", m_src_getn); end
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", byte_valid); end
        if (byte_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b, required 0", byte_last); end
        if (byte_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h, required 00", byte_data); end
        if (m_endn !== 1'b1) begin n_fail++; $display("FAIL rst_endn: got %b, required 1", m_endn); end
    endtask

    task automatic test_stream16();
        int first, last, endn_c;
        do_reset();
        load_job(8'h00, 2, 16);
        fi_cnt = 16; ce = 1; byte_ready = 1;
        first = -1; last = -1; endn_c = -1;
        for (int c = 0; c < 60 && endn_c < 0; c++) begin
            @(negedge clk);
            if (byte_valid && first < 0) first = c;
            if (byte_valid && byte_last) last = c;
            if (m_endn === 1'b0) endn_c = c;
        end
        repeat (3) @(negedge clk);
        n_tests += 4;
        if (n_pops != 2) begin n_fail++; $display("FAIL s16_pops: got %0d, required 2", n_pops); end
        if (first < 0 || last - first != 15) begin
            n_fail++; $display("FAIL s16_no_bubble: got span %0d, required 15", last - first);
        end
        if (last < 0 || endn_c != last + 1) begin
            n_fail++; $display("FAIL s16_endn_time: got cycle %0d, required %0d", endn_c, last + 1);
        end
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL s16_all_bytes: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_tail11();
        bit ok;
        do_reset();
        load_job(8'h00, 3, 11);
        fi_cnt = 11; ce = 1; byte_ready = 1;
        wait_endn(60, ok);
        repeat (3) @(negedge clk);
        n_tests += 4;
        if (!ok) begin n_fail++; $display("FAIL t11_endn: got timeout, required m_endn=0"); end
        if (n_pops != 2) begin n_fail++; $display("FAIL t11_pops: got %0d, required 2", n_pops); end
        if (fifo.size() != 1) begin n_fail++; $display("FAIL t11_fifo_left: got %0d, required 1", fifo.size()); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL t11_all_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_zero();
        bit ok;
        int vseen;
        do_reset();
        load_job(8'h00, 1, 0);
        fi_cnt = 0; ce = 1; byte_ready = 1;
        wait_endn(2, ok);
        vseen = 0;
        repeat (10) begin
            @(negedge clk);
            if (byte_valid) vseen++;
        end
        n_tests += 3;
        if (!ok) begin n_fail++; $display("FAIL z_endn: got m_endn=%b after 2 cycles, required 0", m_endn); end
        if (n_pops != 0) begin n_fail++; $display("FAIL z_pops: got %0d, required 0", n_pops); end
        if (vseen != 0) begin n_fail++; $display("FAIL z_valid: got %0d valid cycles, required 0", vseen); end
    endtask

    task automatic test_backpressure24();
        bit ok, saw_pop;
        int hold;
        do_reset();
        load_job(8'h20, 3, 24);
        fi_cnt = 24; ce = 1; byte_ready = 1;
        chk_stable = 1; saw_pop = 0; hold = 0; ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            byte_ready = ~byte_ready;
            if (saw_pop && hold < 20) begin
                m_src_empty = 1; hold++;
            end else begin
                m_src_empty = 0;
            end
            @(negedge clk);
            if (!m_src_getn) saw_pop = 1;
            if (m_endn === 1'b0) ok = 1;
        end
        chk_stable = 0; byte_ready = 1; m_src_empty = 0;
        repeat (3) @(negedge clk);
        n_tests += 3;
        if (!ok) begin n_fail++; $display("FAIL bp_endn: got timeout, required m_endn=0"); end
        if (n_pops != 3) begin n_fail++; $display("FAIL bp_pops: got %0d, required 3", n_pops); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_all_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_ce_gap();
        bit ok;
        int seen, gap_v, gap_p;
        do_reset();
        load_job(8'h60, 2, 16);
        fi_cnt = 16; ce = 1; byte_ready = 1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(negedge clk);
            if (!m_src_getn) seen++;
        end
        @(posedge clk); #1;
        ce = 0;
        gap_v = 0; gap_p = 0;
        repeat (5) begin
            @(negedge clk);
            if (byte_valid) gap_v++;
            if (!m_src_getn) gap_p++;
        end
        @(posedge clk); #1;
        ce = 1;
        wait_endn(60, ok);
        repeat (3) @(negedge clk);
        n_tests += 6;
        if (seen != 2) begin n_fail++; $display("FAIL ce_second_pop: got %0d pops seen, required 2", seen); end
        if (gap_v != 0) begin n_fail++; $display("FAIL ce_gap_valid: got %0d, required 0", gap_v); end
        if (gap_p != 0) begin n_fail++; $display("FAIL ce_gap_pop: got %0d, required 0", gap_p); end
        if (!ok) begin n_fail++; $display("FAIL ce_endn: got timeout, required m_endn=0"); end
        if (n_pops != 2) begin n_fail++; $display("FAIL ce_pops: got %0d, required 2", n_pops); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ce_all_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acc;
        do_reset();
        load_job(8'h40, 2, 16);
        fi_cnt = 16; ce = 1; byte_ready = 1;
        acc = 0;
        for (int c = 0; c < 60 && acc < 5; c++) begin
            @(negedge clk);
            if (byte_valid && byte_ready) acc++;
        end
        @(posedge clk); #1;
        rst = 1; ce = 0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests += 6;
        if (acc != 5) begin n_fail++; $display("FAIL rm_accepted: got %0d, required 5", acc); end
        if (m_src_getn !== 1'b1) begin n_fail++; $display("FAIL rm_getn: got %b, required 1", m_src_getn); end
        if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b, required 0", byte_valid); end
        if (byte_last !== 1'b0) begin n_fail++; $display("FAIL rm_last: got %b, required 0", byte_last); end
        if (byte_data !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h, required 00", byte_data); end
        if (m_endn !== 1'b1) begin n_fail++; $display("FAIL rm_endn: got %b, required 1", m_endn); end
        fifo.delete(); exp_q.delete(); n_pops = 0;
        @(posedge clk); #1;
        rst = 0;
        load_job(8'h80, 2, 11);
        fi_cnt = 11; ce = 1;
        wait_endn(60, ok);
        repeat (3) @(negedge clk);
        n_tests += 3;
        if (!ok) begin n_fail++; $display("FAIL rm_restart_endn: got timeout, required m_endn=0"); end
        if (n_pops != 2) begin n_fail++; $display("FAIL rm_restart_pops: got %0d, required 2", n_pops); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rm_restart_bytes: got %0d left, required 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1; ce = 0; fi = '0; fi_cnt = '0; m_src_empty = 0; byte_ready = 1;
        test_reset();
        test_stream16();
        test_tail11();
        test_zero();
        test_backpressure24();
        test_ce_gap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lzf_src_fetch.md
Name: lzf_src_fetch

Overview:
- Encoder-side reader of the 64-bit source-word FIFO interface (m_src_empty / m_src_getn / fi / fi_cnt).
- Pops words from the source FIFO and serialises them little-endian into a byte stream with valid/ready for the LZS compressor core.
- Counts down the fi_cnt byte budget, trims the final partial word, and drives m_endn low once the last byte is accepted.
- Holds a one-word prefetch so consecutive words stream with no bubble while the FIFO is non-empty.

Parameters:
- LZF_WIDTH, 20, width of fi_cnt and all internal byte/word counters.
- LZF_WORD_BYTES, 8, bytes per FIFO word; fixed at 8, present for readability only.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  enable; 0 freezes fetch and byte output.
- fi_cnt  input  LZF_WIDTH  total source bytes for the job.
- m_src_empty  input  1  source FIFO empty or almost empty; no pop allowed while 1.
- m_src_getn  output  1  active-low pop strobe; fi is valid the cycle after a low cycle.
- fi  input  64  FIFO read data; byte 0 = fi[7:0].
- byte_data  output  8  current byte.
- byte_valid  output  1  byte_data valid.
- byte_last  output  1  final byte of the job; qualified by byte_valid.
- byte_ready  input  1  core accepts the byte when byte_valid && byte_ready.
- m_endn  output  1  active-low end of job.

Behaviour:
- Reset values: m_src_getn=1, byte_valid=0, byte_last=0, byte_data=0, m_endn=1.
- Reset clears both buffers, all counters and the in-flight flag. Read data returning after a reset is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on the first cycle with ce=1:
  - latch bytes_left = fi_cnt;
  - latch words_left = ceil(fi_cnt/8), i.e. (fi_cnt+7)>>3, computed at LZF_WIDTH+1 bits;
  - latch tail = fi_cnt[2:0].
- If the latched fi_cnt = 0, go IDLE -> DONE directly. No pop is issued.
- Pop rule in RUN: m_src_getn = 0 (combinational) only when all of the following hold:
  - ce=1, m_src_empty=0, words_left>0;
  - no read is in flight;
  - the nxt buffer is empty.
- On a pop, words_left is decremented and in_flight is set. One pop per two cycles at most.
- Return cycle (the cycle after a pop):
  - fi loads cur if cur is empty, or is being emptied this cycle by acceptance of its last byte; otherwise fi loads nxt.
  - in_flight clears.
  - Valid-byte count per word: 8, except the final word of the job, which uses tail if tail is nonzero.
- Byte output:
  - byte_valid = ce && cur_valid; byte_data = cur[7:0].
  - On accept, cur shifts right by 8 and bytes_left decrements.
  - byte_last = byte_valid && (bytes_left == 1).
  - After the last byte of cur is accepted, nxt moves into cur in the same edge if nxt is valid.
- ce=0 mid-job:
  - no new pops; byte_valid=0; state and counters hold;
  - a read already in flight still captures fi.
- Acceptance of the final byte -> DONE. In DONE, m_endn=0 registered (asserted the cycle after acceptance) and held until rst. No further pops. Remaining FIFO content is ignored.
- m_src_empty toggling:
  - the pop rule is re-evaluated every cycle;
  - byte output continues from the buffers independently of the FIFO state.
- byte_ready=0: the byte is held stable. byte_data, byte_valid and byte_last must not change until accepted.

Decomposition:
- Shared package lzf_pkg:
  - FSM state encoding;
  - LZF_WORD_BYTES constant;
  - the word-count helper (fi_cnt+7)>>3.
- One natural sub-module, lzf_word_shifter: a single 64-bit load/shift register with a byte-count field. Instantiate it twice, for cur and nxt.

Test Plan:
- fi_cnt=16, FIFO preloaded with 0x0706050403020100 and 0x0F0E0D0C0B0A0908, byte_ready=1:
  - exactly 2 pops;
  - bytes 0x00..0x0F on consecutive cycles with no bubble;
  - byte_last only on 0x0F;
  - m_endn low one cycle later.
- fi_cnt=11: 2 pops; second word yields only 3 bytes (0x08,0x09,0x0A); byte_last on 0x0A; the extra FIFO word is never popped.
- fi_cnt=0, ce=1: no pop ever; byte_valid stays 0; m_endn low within 2 cycles.
- fi_cnt=24 with byte_ready toggling 1/0 and m_src_empty held 1 for 20 cycles after word 1:
  - no pop while empty;
  - byte_data stable whenever byte_ready=0;
  - all 24 bytes delivered in order.
- ce dropped for 5 cycles mid-word, with a read in flight:
  - byte_valid=0 during the gap;
  - the in-flight word is captured;
  - the stream resumes at the correct next byte with no loss or duplication.
- rst pulsed mid-job (after 5 of 16 bytes):
  - all outputs return to reset values;
  - the next job restarts from fresh fi_cnt;
  - a stale returning word is not emitted.
